ah_block_regs: RTL and testbench

Parametrised message-block and chaining-state register file for the hash datapath; successor to the fixed 16×32 MD5 register set. Accepts message words over a valid/ready handshake into two ping-pong block buffers, so the next block fills while the round core consumes the current one. Holds the working state and the saved chaining state, and performs the end-of-block feed-forward add (state + chaining, mod 2^WORD_W). Sits between the input packer and the round-function core; STATE_WORDS selects MD5 (4) or SHA-1 (5) state.

---
 rtl/ah_pkg.sv | 21 ++
 rtl/ah_blk_pingpong.sv | 91 +++++++++
 rtl/ah_block_regs.sv | 71 +++++++
 tb/tb_ah_block_regs.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_pkg.sv
// Shared constants for the hash message-block / chaining-state register file.
package ah_pkg;

  localparam int unsigned WORD_W_DEF       = 32;
  localparam int unsigned BLOCK_WORDS_DEF  = 16;
  localparam int unsigned MD5_STATE_WORDS  = 4;
  localparam int unsigned SHA1_STATE_WORDS = 5;
  localparam int unsigned STATE_WORDS_DEF  = MD5_STATE_WORDS;

  // Initial values, word 0 (A) in the LSBs
  localparam logic [127:0] MD5_IV  = {32'h10325476, 32'h98badcfe,
                                      32'hefcdab89, 32'h67452301};
  localparam logic [159:0] SHA1_IV = {32'hc3d2e1f0, 32'h10325476, 32'h98badcfe,
                                      32'hefcdab89, 32'h67452301};

  // Width of a counter that indexes n words (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ah_blk_pingpong.sv
// Two-bank ping-pong message-block buffer with valid/ready fill and block release.
module ah_blk_pingpong
  import ah_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          data_vld,
  output logic                          data_rdy,
  input  logic [WORD_W-1:0]             data_in,
  output logic                          blk_vld,
  input  logic                          blk_rel,
  output logic [BLOCK_WORDS*WORD_W-1:0] blk_out
);

  localparam int unsigned BLK_W = BLOCK_WORDS * WORD_W;
  localparam int unsigned CNT_W = cnt_width(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

  logic [BLK_W-1:0] bank [2];
  logic [1:0]       full, fullNxt;
  logic             wrBank, wrBankNxt;
  logic             rdBank, rdBankNxt;
  logic [CNT_W-1:0] wrCnt, wrCntNxt;
  logic             accept;
  logic             relEff;

  // Handshake outputs come from registers only
  always_comb begin
    data_rdy = ~full[wrBank];
    blk_vld  = full[rdBank];
    blk_out  = bank[rdBank];
    accept   = data_vld & data_rdy & ~flush;
    relEff   = blk_rel & blk_vld & ~flush;
  end

  // Next pointers, fill count and full flags; flush overrides accept and release
  always_comb begin
    fullNxt   = full;
    wrBankNxt = wrBank;
    rdBankNxt = rdBank;
    wrCntNxt  = wrCnt;
    if (flush) begin
      fullNxt   = 2'b00;
      wrBankNxt = 1'b0;
      rdBankNxt = 1'b0;
      wrCntNxt  = '0;
    end else begin
      if (accept) begin
        if (wrCnt == LAST_CNT) begin
          fullNxt[wrBank] = 1'b1;
          wrBankNxt       = ~wrBank;
          wrCntNxt        = '0;
        end else begin
          wrCntNxt = wrCnt + CNT_W'(1);
        end
      end
      // A completing fill and a release always hit different banks
      if (relEff) begin
        fullNxt[rdBank] = 1'b0;
        rdBankNxt       = ~rdBank;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 2'b00;
      wrBank <= 1'b0;
      rdBank <= 1'b0;
      wrCnt  <= '0;
    end else begin
      full   <= fullNxt;
      wrBank <= wrBankNxt;
      rdBank <= rdBankNxt;
      wrCnt  <= wrCntNxt;
    end
  end

  // Bank storage shifts toward the top word; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      bank[wrBank] <= {bank[wrBank][BLK_W-WORD_W-1:0], data_in};
    end
  end

endmodule

// File: rtl/ah_block_regs.sv
// Message-block buffer plus working/chaining state registers with feed-forward add.
module ah_block_regs
  import ah_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned STATE_WORDS = STATE_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          data_vld,
  output logic                          data_rdy,
  input  logic [WORD_W-1:0]             data_in,
  output logic                          blk_vld,
  input  logic                          blk_rel,
  output logic [BLOCK_WORDS*WORD_W-1:0] blk_out,
  input  logic                          state_load,
  input  logic [STATE_WORDS*WORD_W-1:0] state_in,
  input  logic                          round_en,
  input  logic [STATE_WORDS*WORD_W-1:0] state_comb,
  input  logic                          fold,
  output logic [STATE_WORDS*WORD_W-1:0] state_reg,
  output logic [STATE_WORDS*WORD_W-1:0] chain_reg
);

  localparam int unsigned ST_W = STATE_WORDS * WORD_W;

  logic [ST_W-1:0] foldSum;

  ah_blk_pingpong #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) uPingpong (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .data_vld (data_vld),
    .data_rdy (data_rdy),
    .data_in  (data_in),
    .blk_vld  (blk_vld),
    .blk_rel  (blk_rel),
    .blk_out  (blk_out)
  );

  // Word-wise feed-forward add; carries stay inside each word
  always_comb begin
    foldSum = '0;
    for (int unsigned i = 0; i < STATE_WORDS; i++) begin
      foldSum[i*WORD_W +: WORD_W] = state_reg[i*WORD_W +: WORD_W]
                                  + chain_reg[i*WORD_W +: WORD_W];
    end
  end

  // Working and chaining state: load beats fold beats round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      chain_reg <= '0;
    end else if (state_load) begin
      state_reg <= state_in;
      chain_reg <= state_in;
    end else if (fold) begin
      state_reg <= foldSum;
      chain_reg <= foldSum;
    end else if (round_en) begin
      state_reg <= state_comb;
    end
  end

endmodule

// File: tb/tb_ah_block_regs.sv
// Self-checking bench for ah_block_regs: MD5-sized and SHA-1-sized instances.
module tb_ah_block_regs;
  import ah_pkg::*;

  localparam int WW    = 32;
  localparam int BW    = 16;
  localparam int BLK_W = WW * BW;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, data_vld, blk_rel;
  logic [WW-1:0] data_in;
  logic state_load, round_en, fold;
  logic [159:0] state_in, state_comb;

  logic rdy4, vld4, rdy5, vld5;
  logic [BLK_W-1:0] blk4, blk5;
  logic [127:0] st4, ch4;
  logic [159:0] st5, ch5;

  int errors = 0;
  int checks = 0;

  // Reference model: completed blocks in arrival order, partial fill, state words
  logic [31:0] mBlk [2][BW];
  logic [31:0] mPart [BW];
  int mHead, mCount, mPartCnt;
  logic [31:0] mSt [5];
  logic [31:0] mCh [5];

  always #5 clk = ~clk;

  ah_block_regs #(.WORD_W(WW), .BLOCK_WORDS(BW), .STATE_WORDS(MD5_STATE_WORDS)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_vld(data_vld), .data_rdy(rdy4),
    .data_in(data_in), .blk_vld(vld4), .blk_rel(blk_rel), .blk_out(blk4),
    .state_load(state_load), .state_in(state_in[127:0]), .round_en(round_en),
    .state_comb(state_comb[127:0]), .fold(fold), .state_reg(st4), .chain_reg(ch4));

  ah_block_regs #(.WORD_W(WW), .BLOCK_WORDS(BW), .STATE_WORDS(SHA1_STATE_WORDS)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_vld(data_vld), .data_rdy(rdy5),
    .data_in(data_in), .blk_vld(vld5), .blk_rel(blk_rel), .blk_out(blk5),
    .state_load(state_load), .state_in(state_in), .round_en(round_en),
    .state_comb(state_comb), .fold(fold), .state_reg(st5), .chain_reg(ch5));

  // Presented block: first-arrived word at the top index
  function automatic logic [BLK_W-1:0] expBlk();
    logic [BLK_W-1:0] r;
    for (int k = 0; k < BW; k++) r[k*WW +: WW] = mBlk[mHead][BW-1-k];
    return r;
  endfunction

  function automatic logic [159:0] packSt();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = mSt[i];
    return r;
  endfunction

  function automatic logic [159:0] packCh();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = mCh[i];
    return r;
  endfunction

  task automatic model_clear();
    mHead = 0; mCount = 0; mPartCnt = 0;
    for (int i = 0; i < 5; i++) begin mSt[i] = '0; mCh[i] = '0; end
  endtask

  // One clock of handshake stimulus; the model follows the block-level rules
  task automatic drive_cycle(input logic vld, input logic [31:0] w, input logic rel, input logic fl);
    bit acc, re;
    int slot;
    data_vld = vld; data_in = w; blk_rel = rel; flush = fl;
    acc = vld && (mCount < 2) && !fl;
    re  = rel && (mCount > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      mCount = 0; mHead = 0; mPartCnt = 0;
    end else begin
      if (re) begin mHead ^= 1; mCount--; end
      if (acc) begin
        mPart[mPartCnt] = w;
        mPartCnt++;
        if (mPartCnt == BW) begin
          slot = (mHead + mCount) % 2;
          for (int k = 0; k < BW; k++) mBlk[slot][k] = mPart[k];
          mCount++;
          mPartCnt = 0;
        end
      end
    end
    #1;
    data_vld = 1'b0; blk_rel = 1'b0; flush = 1'b0;
  endtask

  // One clock of state stimulus
  task automatic state_cycle(input logic ld, input logic fd, input logic rd,
                             input logic [159:0] sin, input logic [159:0] comb);
    state_load = ld; fold = fd; round_en = rd; state_in = sin; state_comb = comb;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      if (ld) begin
        mSt[i] = sin[i*32 +: 32]; mCh[i] = sin[i*32 +: 32];
      end else if (fd) begin
        mSt[i] = mSt[i] + mCh[i]; mCh[i] = mSt[i];
      end else if (rd) begin
        mSt[i] = comb[i*32 +: 32];
      end
    end
    #1;
    state_load = 1'b0; fold = 1'b0; round_en = 1'b0;
  endtask

  function automatic logic [159:0] rand160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    #1;
    checks++; if (rdy4 !== 1'b1 || rdy5 !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b/%b want 1", rdy4, rdy5); end
    checks++; if (vld4 !== 1'b0 || vld5 !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b/%b want 0", vld4, vld5); end
    checks++; if (st4 !== '0 || ch4 !== '0) begin errors++; $display("FAIL reset_state4: got %h/%h want 0", st4, ch4); end
    checks++; if (st5 !== '0 || ch5 !== '0) begin errors++; $display("FAIL reset_state5: got %h/%h want 0", st5, ch5); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midfill();
    logic [BLK_W-1:0] e;
    state_cycle(1'b1, 1'b0, 1'b0, SHA1_IV, '0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL midreset_vld: got %b want 0", vld4); end
    checks++; if (dut4.uPingpong.wrCnt !== '0) begin errors++; $display("FAIL midreset_wrcnt: got %0d want 0", dut4.uPingpong.wrCnt); end
    checks++; if (st5 !== '0 || ch5 !== '0) begin errors++; $display("FAIL midreset_state: got %h/%h want 0", st5, ch5); end
    @(posedge clk); #1 rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < BW; i++) begin
      drive_cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      checks++; if (vld4 !== (i == BW-1)) begin errors++; $display("FAIL midreset_refill_vld%0d: got %b want %b", i, vld4, (i == BW-1)); end
    end
    e = expBlk();
    checks++; if (blk4 !== e) begin errors++; $display("FAIL midreset_blk: got %h want %h", blk4, e); end
    checks++; if (blk4[31:0] !== 32'h10f) begin errors++; $display("FAIL midreset_word0: got %h want 10f", blk4[31:0]); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_stream();
    logic [BLK_W-1:0] e;
    for (int i = 1; i <= BW; i++) begin
      drive_cycle(1'b1, 32'(i), 1'b0, 1'b0);
      checks++; if (vld4 !== (i == BW)) begin errors++; $display("FAIL stream_vld%0d: got %b want %b", i, vld4, (i == BW)); end
    end
    checks++; if (blk4[31:0] !== 32'h10) begin errors++; $display("FAIL stream_word0: got %h want 10", blk4[31:0]); end
    checks++; if (blk4[BLK_W-1 -: 32] !== 32'h1) begin errors++; $display("FAIL stream_word15: got %h want 1", blk4[BLK_W-1 -: 32]); end
    e = expBlk();
    checks++; if (blk5 !== e) begin errors++; $display("FAIL stream_blk5: got %h want %h", blk5, e); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL stream_release: got %b want 0", vld4); end
  endtask

  task automatic test_back_to_back();
    logic [BLK_W-1:0] e;
    int stalls = 0;
    for (int i = 0; i < 4*BW; i++) begin
      if (rdy4 !== 1'b1) stalls++;
      drive_cycle(1'b1, $urandom, (i % BW) == 3 && i >= BW, 1'b0);
    end
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    checks++; if (vld4 !== 1'b1) begin errors++; $display("FAIL b2b_vld: got %b want 1", vld4); end
    e = expBlk();
    checks++; if (blk4 !== e) begin errors++; $display("FAIL b2b_blk: got %h want %h", blk4, e); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", vld4); end
  endtask

  task automatic test_backpressure();
    logic [BLK_W-1:0] e;
    for (int w = 0; w < 2*BW; w++) begin
      checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL bp_rdy_w%0d: got %b want 1", w, rdy4); end
      drive_cycle(1'b1, 32'h200 + 32'(w), 1'b0, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      checks++; if (rdy4 !== 1'b0 || vld4 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: rdy=%b vld=%b want 0/1", c, rdy4, vld4); end
      drive_cycle(1'b1, 32'h220, 1'b0, 1'b0);
    end
    drive_cycle(1'b1, 32'h220, 1'b1, 1'b0);
    checks++; if (rdy4 !== 1'b1 || vld4 !== 1'b1) begin errors++; $display("FAIL bp_after_rel: rdy=%b vld=%b want 1/1", rdy4, vld4); end
    checks++; if (blk4[31:0] !== 32'h21f || blk4[BLK_W-1 -: 32] !== 32'h210) begin errors++; $display("FAIL bp_second_bank: got %h..%h want 210..21f", blk4[BLK_W-1 -: 32], blk4[31:0]); end
    for (int w = 0; w < BW; w++) drive_cycle(1'b1, 32'h220 + 32'(w), 1'b0, 1'b0);
    e = expBlk();
    checks++; if (vld4 !== 1'b1 || blk4 !== e) begin errors++; $display("FAIL bp_still_second: vld=%b got %h want %h", vld4, blk4, e); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (blk4[31:0] !== 32'h22f || blk4[BLK_W-1 -: 32] !== 32'h220) begin errors++; $display("FAIL bp_held_word: got %h..%h want 220..22f", blk4[BLK_W-1 -: 32], blk4[31:0]); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", vld4); end
  endtask

  task automatic test_flush();
    state_cycle(1'b1, 1'b0, 1'b0, {32'h0, MD5_IV}, '0);
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 32'h70 + 32'(i), 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h99, 1'b0, 1'b1);
    checks++; if (vld4 !== 1'b0 || rdy4 !== 1'b1) begin errors++; $display("FAIL flush_flags: vld=%b rdy=%b want 0/1", vld4, rdy4); end
    checks++; if (st4 !== MD5_IV || ch4 !== MD5_IV) begin errors++; $display("FAIL flush_state: got %h/%h want %h", st4, ch4, MD5_IV); end
    for (int i = 0; i < BW; i++) begin
      drive_cycle(1'b1, 32'ha0 + 32'(i), 1'b0, 1'b0);
      checks++; if (vld4 !== (i == BW-1)) begin errors++; $display("FAIL flush_refill_vld%0d: got %b want %b", i, vld4, (i == BW-1)); end
    end
    checks++; if (blk4[31:0] !== 32'haf || blk4[BLK_W-1 -: 32] !== 32'ha0) begin errors++; $display("FAIL flush_block: got %h..%h want a0..af", blk4[BLK_W-1 -: 32], blk4[31:0]); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL flush_one_block: got %b want 0", vld4); end
  endtask

  task automatic test_md5_fold();
    logic [159:0] comb, e;
    state_cycle(1'b1, 1'b0, 1'b0, {32'h0, MD5_IV}, '0);
    checks++; if (st4 !== MD5_IV || ch4 !== MD5_IV) begin errors++; $display("FAIL md5_load: got %h/%h want %h", st4, ch4, MD5_IV); end
    comb = rand160();
    comb[31:0] = 32'h98badcff;
    state_cycle(1'b0, 1'b0, 1'b1, '0, comb);
    checks++; if (st4 !== comb[127:0] || ch4 !== MD5_IV) begin errors++; $display("FAIL md5_round: got %h/%h want %h/%h", st4, ch4, comb[127:0], MD5_IV); end
    state_cycle(1'b0, 1'b1, 1'b0, '0, '0);
    checks++; if (st4[31:0] !== 32'h0 || ch4[31:0] !== 32'h0) begin errors++; $display("FAIL md5_fold_A: got %h/%h want 0", st4[31:0], ch4[31:0]); end
    e = {32'h0, comb[127:96] + 32'h10325476, comb[95:64] + 32'h98badcfe, comb[63:32] + 32'hefcdab89, 32'h0};
    checks++; if (st4 !== e[127:0] || ch4 !== e[127:0]) begin errors++; $display("FAIL md5_fold: got %h/%h want %h", st4, ch4, e[127:0]); end
  endtask

  task automatic test_sha1();
    logic [159:0] comb, e, v;
    state_cycle(1'b1, 1'b0, 1'b0, SHA1_IV, '0);
    checks++; if (st5[159:128] !== 32'hc3d2e1f0 || ch5 !== SHA1_IV) begin errors++; $display("FAIL sha1_load: got %h/%h want %h", st5, ch5, SHA1_IV); end
    comb = rand160();
    state_cycle(1'b0, 1'b0, 1'b1, '0, comb);
    state_cycle(1'b0, 1'b1, 1'b0, '0, '0);
    e = packSt();
    checks++; if (st5 !== e || ch5 !== e) begin errors++; $display("FAIL sha1_fold: got %h/%h want %h", st5, ch5, e); end
    checks++; if (st5[159:128] !== comb[159:128] + 32'hc3d2e1f0) begin errors++; $display("FAIL sha1_fold_E: got %h want %h", st5[159:128], comb[159:128] + 32'hc3d2e1f0); end
    v = rand160();
    state_cycle(1'b1, 1'b1, 1'b1, v, rand160());
    checks++; if (st5 !== v || ch5 !== v) begin errors++; $display("FAIL sha1_load_wins: got %h/%h want %h", st5, ch5, v); end
    state_cycle(1'b0, 1'b1, 1'b1, '0, rand160());
    e = packSt();
    checks++; if (st5 !== e) begin errors++; $display("FAIL sha1_fold_wins: got %h want %h", st5, e); end
  endtask

  task automatic test_random_stream();
    logic [BLK_W-1:0] e;
    for (int c = 0; c < 400; c++) begin
      drive_cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 60) == 0);
      checks++; if (rdy4 !== (mCount < 2) || rdy5 !== (mCount < 2)) begin errors++; $display("FAIL rnd_rdy c%0d: got %b/%b want %b", c, rdy4, rdy5, (mCount < 2)); end
      checks++; if (vld4 !== (mCount > 0) || vld5 !== (mCount > 0)) begin errors++; $display("FAIL rnd_vld c%0d: got %b/%b want %b", c, vld4, vld5, (mCount > 0)); end
      if (mCount > 0) begin
        e = expBlk();
        checks++; if (blk4 !== e || blk5 !== e) begin errors++; $display("FAIL rnd_blk c%0d: got %h want %h", c, blk4, e); end
      end
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random_state();
    logic [159:0] es, ec;
    for (int c = 0; c < 80; c++) begin
      state_cycle(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0, rand160(), rand160());
      es = packSt(); ec = packCh();
      checks++; if (st5 !== es || ch5 !== ec) begin errors++; $display("FAIL rnd_state5 c%0d: got %h/%h want %h/%h", c, st5, ch5, es, ec); end
      checks++; if (st4 !== es[127:0] || ch4 !== ec[127:0]) begin errors++; $display("FAIL rnd_state4 c%0d: got %h/%h want %h/%h", c, st4, ch4, es[127:0], ec[127:0]); end
    end
  endtask

  initial begin
    flush = 1'b0; data_vld = 1'b0; blk_rel = 1'b0; data_in = '0;
    state_load = 1'b0; round_en = 1'b0; fold = 1'b0;
    state_in = '0; state_comb = '0;
    model_clear();
    test_reset();
    test_reset_midfill();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_md5_fold();
    test_sha1();
    test_random_stream();
    test_random_state();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
